// File: rtl/sparc_mem_pkg.sv
// sparc_mem_pkg
//   Shared definitions for the SPARC datapath RAM responder: op3 codes of the
//   supported load/store instructions, access-size and FSM state encodings,
//   and the op3 decoder used by the responder.
//   Related build option: RAM_ALIGN_CHECK_EN (consumed by sparc_ram_responder).
package sparc_mem_pkg;

    // op3 field values of the supported memory instructions
    localparam logic [5:0] OP3_LD   = 6'b000000;
    localparam logic [5:0] OP3_LDUB = 6'b000001;
    localparam logic [5:0] OP3_LDUH = 6'b000010;
    localparam logic [5:0] OP3_LDSB = 6'b001001;
    localparam logic [5:0] OP3_LDSH = 6'b001010;
    localparam logic [5:0] OP3_ST   = 6'b000100;
    localparam logic [5:0] OP3_STB  = 6'b000101;
    localparam logic [5:0] OP3_STH  = 6'b000110;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } acc_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } fsm_state_e;

    typedef struct packed {
        logic      valid;      // opcode is a supported load/store
        logic      is_store;
        logic      is_signed;  // sign-extend load data
        acc_size_e size;
    } op_info_t;

    // Unsupported opcodes (LDD, STD, SWAP, ...) decode as valid=0, size BYTE,
    // so they never write, never load and never flag misalignment.
    function automatic op_info_t decode_op3(input logic [5:0] op3);
        op_info_t info;
        info = '{valid: 1'b0, is_store: 1'b0, is_signed: 1'b0, size: BYTE};
        case (op3)
            OP3_LD:   info = '{valid: 1'b1, is_store: 1'b0, is_signed: 1'b0, size: WORD};
            OP3_LDUB: info = '{valid: 1'b1, is_store: 1'b0, is_signed: 1'b0, size: BYTE};
            OP3_LDUH: info = '{valid: 1'b1, is_store: 1'b0, is_signed: 1'b0, size: HALF};
            OP3_LDSB: info = '{valid: 1'b1, is_store: 1'b0, is_signed: 1'b1, size: BYTE};
            OP3_LDSH: info = '{valid: 1'b1, is_store: 1'b0, is_signed: 1'b1, size: HALF};
            OP3_ST:   info = '{valid: 1'b1, is_store: 1'b1, is_signed: 1'b0, size: WORD};
            OP3_STB:  info = '{valid: 1'b1, is_store: 1'b1, is_signed: 1'b0, size: BYTE};
            OP3_STH:  info = '{valid: 1'b1, is_store: 1'b1, is_signed: 1'b0, size: HALF};
            default:  info = '{valid: 1'b0, is_store: 1'b0, is_signed: 1'b0, size: BYTE};
        endcase
        return info;
    endfunction

endpackage

// File: rtl/ram_lane_align.sv
// ram_lane_align
//   Combinational byte-lane steering for a big-endian 32-bit memory word.
//   Byte offset 0 is bits 31:24.
//   Ports:
//     mem_word_i   current contents of the addressed aligned word
//     offset_i     byte offset inside the word (already aligned for half/word)
//     size_i       access size
//     is_signed_i  sign-extend loads
//     st_data_i    right-justified store data
//     ld_data_o    right-justified, extended load data
//     wr_word_o    store data replicated onto every lane
//     wr_mask_o    byte-lane write mask, bit 3 = offset 0
module ram_lane_align
    import sparc_mem_pkg::*;
(
    input  logic [31:0] mem_word_i,
    input  logic [1:0]  offset_i,
    input  acc_size_e   size_i,
    input  logic        is_signed_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] wr_word_o,
    output logic [3:0]  wr_mask_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Load path: pick the addressed lane(s) and extend
    always_comb begin
        byte_s    = 8'd0;
        half_s    = 16'd0;
        ld_data_o = 32'd0;
        case (offset_i)
            2'd0:    byte_s = mem_word_i[31:24];
            2'd1:    byte_s = mem_word_i[23:16];
            2'd2:    byte_s = mem_word_i[15:8];
            2'd3:    byte_s = mem_word_i[7:0];
            default: byte_s = 8'd0;
        endcase
        if (offset_i[1]) begin
            half_s = mem_word_i[15:0];
        end else begin
            half_s = mem_word_i[31:16];
        end
        case (size_i)
            BYTE:    ld_data_o = {{24{is_signed_i & byte_s[7]}}, byte_s};
            HALF:    ld_data_o = {{16{is_signed_i & half_s[15]}}, half_s};
            WORD:    ld_data_o = mem_word_i;
            default: ld_data_o = mem_word_i;
        endcase
    end

    // Store path: replicate data on all lanes, the mask selects which land
    always_comb begin
        wr_word_o = 32'd0;
        wr_mask_o = 4'b0000;
        case (size_i)
            BYTE: begin
                wr_word_o = {4{st_data_i[7:0]}};
                wr_mask_o = 4'b1000 >> offset_i;
            end
            HALF: begin
                wr_word_o = {2{st_data_i[15:0]}};
                wr_mask_o = offset_i[1] ? 4'b0011 : 4'b1100;
            end
            WORD: begin
                wr_word_o = st_data_i;
                wr_mask_o = 4'b1111;
            end
            default: begin
                wr_word_o = 32'd0;
                wr_mask_o = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/sparc_ram_responder.sv
// sparc_ram_responder
//   Byte-addressed big-endian RAM with a 4-phase RAM_enable/MFC handshake and
//   a fixed access latency. A request is captured on acceptance, the access
//   happens LATENCY cycles later together with MFC rising, and MFC stays high
//   until RAM_enable drops.
//   Build option RAM_ALIGN_CHECK_EN: when defined, misaligned half/word
//   accesses are suppressed and reported on align_err; when undefined the low
//   address bits are forced to alignment and align_err is tied 0.
//   Ports:
//     Clk, RESET            clock, synchronous active-high reset
//     RAM_enable            request strobe, held until MFC is seen
//     RAM_OpCode            SPARC op3
//     Address, DataIn       byte address and right-justified store data
//     DataOut               registered load data, held between accesses
//     MFC                   memory function complete
//     align_err             misalignment flag, valid while MFC=1
module sparc_ram_responder
    import sparc_mem_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int LATENCY = 2
)(
    input  logic              Clk,
    input  logic              RESET,
    input  logic              RAM_enable,
    input  logic [5:0]        RAM_OpCode,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MFC,
    output logic              align_err
);

    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    fsm_state_e        state_q;
    logic [3:0]        cnt_q;
    logic [5:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic [31:0]       dout_q;
    logic              mfc_q;
    logic [7:0]        mem_q [0:DEPTH-1];

    op_info_t          info_s;
    logic [ADDR_W-3:0] base_hi_s;
    logic [1:0]        offset_s;
    logic [31:0]       mem_word_s;
    logic              misalign_s;
    logic              fire_s;
    logic              wr_en_s;
    logic [31:0]       ld_data_d;
    logic [31:0]       wr_word_d;
    logic [3:0]        wr_mask_d;

    assign info_s    = decode_op3(op_q);
    assign base_hi_s = addr_q[ADDR_W-1:2];
    assign fire_s    = (state_q == WAIT) && (cnt_q == 4'd0);
    assign mem_word_s = {mem_q[{base_hi_s, 2'b00}], mem_q[{base_hi_s, 2'b01}],
                         mem_q[{base_hi_s, 2'b10}], mem_q[{base_hi_s, 2'b11}]};

    // Lane offset: half/word accesses always use their naturally aligned lanes
    always_comb begin
        offset_s = addr_q[1:0];
        case (info_s.size)
            WORD:    offset_s = 2'b00;
            HALF:    offset_s = {addr_q[1], 1'b0};
            BYTE:    offset_s = addr_q[1:0];
            default: offset_s = addr_q[1:0];
        endcase
    end

`ifdef RAM_ALIGN_CHECK_EN
    logic aerr_q;

    // Misalignment detection on the latched request
    always_comb begin
        misalign_s = 1'b0;
        case (info_s.size)
            HALF:    misalign_s = addr_q[0];
            WORD:    misalign_s = (addr_q[1:0] != 2'b00);
            default: misalign_s = 1'b0;
        endcase
    end

    // Alignment flag: set alongside MFC, cleared when the handshake closes
    always_ff @(posedge Clk) begin
        if (RESET) begin
            aerr_q <= 1'b0;
        end else if (fire_s) begin
            aerr_q <= misalign_s;
        end else if ((state_q == DONE) && !RAM_enable) begin
            aerr_q <= 1'b0;
        end
    end

    assign align_err = aerr_q;
`else
    assign misalign_s = 1'b0;
    assign align_err  = 1'b0;
`endif

    // RESET is folded in so an aborted store can never reach the array
    assign wr_en_s = fire_s && !RESET && info_s.valid && info_s.is_store && !misalign_s;

    ram_lane_align u_lane (
        .mem_word_i  (mem_word_s),
        .offset_i    (offset_s),
        .size_i      (info_s.size),
        .is_signed_i (info_s.is_signed),
        .st_data_i   (data_q),
        .ld_data_o   (ld_data_d),
        .wr_word_o   (wr_word_d),
        .wr_mask_o   (wr_mask_d)
    );

    // Handshake FSM with latency counter and registered outputs
    always_ff @(posedge Clk) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 6'd0;
            addr_q  <= '0;
            data_q  <= 32'd0;
            dout_q  <= 32'd0;
            mfc_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    mfc_q <= 1'b0;
                    if (RAM_enable) begin
                        op_q    <= RAM_OpCode;
                        addr_q  <= Address;
                        data_q  <= DataIn;
                        cnt_q   <= CNT_INIT;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        mfc_q   <= 1'b1;
                        state_q <= DONE;
                        if (info_s.valid && !info_s.is_store && !misalign_s) begin
                            dout_q <= ld_data_d;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    if (!RAM_enable) begin
                        mfc_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    mfc_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Byte array write port; contents survive reset
    always_ff @(posedge Clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask_d[3-i]) begin
                    mem_q[{base_hi_s, i[1:0]}] <= wr_word_d[8*(3-i) +: 8];
                end
            end
        end
    end

    assign DataOut = dout_q;
    assign MFC     = mfc_q;

endmodule

// File: tb/tb_sparc_ram_responder.sv
// Testbench for sparc_ram_responder (ADDR_W=9, LATENCY=2). A driver issues
// directed requests and queues the expected response; a monitor compares
// each rising MFC against the queue head (data, align_err, latency).
module tb_sparc_ram_responder;

    localparam int ADDR_W  = 9;
    localparam int LATENCY = 2;

    localparam logic [5:0] T_LD   = 6'b000000;
    localparam logic [5:0] T_LDUB = 6'b000001;
    localparam logic [5:0] T_LDUH = 6'b000010;
    localparam logic [5:0] T_LDSB = 6'b001001;
    localparam logic [5:0] T_LDSH = 6'b001010;
    localparam logic [5:0] T_ST   = 6'b000100;
    localparam logic [5:0] T_STB  = 6'b000101;
    localparam logic [5:0] T_STH  = 6'b000110;
    localparam logic [5:0] T_LDD  = 6'b000011;
    localparam logic [5:0] T_STD  = 6'b000111;
    localparam logic [5:0] T_SWAP = 6'b001111;

`ifdef RAM_ALIGN_CHECK_EN
    localparam logic AE = 1'b1;
`else
    localparam logic AE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              RESET;
    logic              RAM_enable;
    logic [5:0]        RAM_OpCode;
    logic [ADDR_W-1:0] Address;
    logic [31:0]       DataIn;
    logic [31:0]       DataOut;
    logic              MFC;
    logic              align_err;

    sparc_ram_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .Clk        (clk),
        .RESET      (RESET),
        .RAM_enable (RAM_enable),
        .RAM_OpCode (RAM_OpCode),
        .Address    (Address),
        .DataIn     (DataIn),
        .DataOut    (DataOut),
        .MFC        (MFC),
        .align_err  (align_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        aerr;
        int          acc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   mfc_rises = 0;
    int   issued    = 0;
    logic mfc_prev  = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Monitor: every rising MFC must match the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (MFC === 1'b1 && mfc_prev !== 1'b1) begin
            mfc_rises++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_mfc: got MFC rise at cycle %0d expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_data"}, DataOut, e.data);
                check({e.name, "_aerr"}, {31'd0, align_err}, {31'd0, e.aerr});
                check({e.name, "_latency"}, 32'(cyc - e.acc), 32'(LATENCY));
            end
        end
        mfc_prev = MFC;
    end

    // One full handshake; called and returning on a negedge
    task automatic access(input string nm, input logic [5:0] op, input logic [ADDR_W-1:0] a,
                          input logic [31:0] d, input logic [31:0] exp_d, input logic exp_ae,
                          input int hold);
        exp_t e;
        bit   seen;
        RAM_OpCode = op;
        Address    = a;
        DataIn     = d;
        RAM_enable = 1'b1;
        e.data = exp_d;
        e.aerr = exp_ae;
        e.acc  = cyc + 1;
        e.name = nm;
        exp_q.push_back(e);
        issued++;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            // inputs may change after acceptance without effect
            Address = ~a;
            DataIn  = ~d;
            if (MFC === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_timeout: got no MFC expected MFC within 20 cycles", nm);
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({nm, "_hold_mfc"}, {31'd0, MFC}, 32'd1);
        end
        RAM_enable = 1'b0;
        @(negedge clk);
        check({nm, "_mfc_drop"}, {31'd0, MFC}, 32'd0);
    endtask

    initial begin
        RESET      = 1'b1;
        RAM_enable = 1'b0;
        RAM_OpCode = 6'd0;
        Address    = '0;
        DataIn     = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_dataout", DataOut, 32'd0);
        check("rst_mfc", {31'd0, MFC}, 32'd0);
        check("rst_aerr", {31'd0, align_err}, 32'd0);
        RESET = 1'b0;
        @(negedge clk);

        access("stw",     T_ST,   9'h010, 32'hDEADBEEF, 32'h00000000, 1'b0, 0);
        access("ld",      T_LD,   9'h010, 32'h0,        32'hDEADBEEF, 1'b0, 0);
        access("ldub",    T_LDUB, 9'h011, 32'h0,        32'h000000AD, 1'b0, 0);
        access("ldsb",    T_LDSB, 9'h010, 32'h0,        32'hFFFFFFDE, 1'b0, 0);
        access("lduh",    T_LDUH, 9'h012, 32'h0,        32'h0000BEEF, 1'b0, 0);
        access("ldsh",    T_LDSH, 9'h012, 32'h0,        32'hFFFFBEEF, 1'b0, 0);
        access("stb",     T_STB,  9'h013, 32'hAABBCC55, 32'hFFFFBEEF, 1'b0, 0);
        access("sth",     T_STH,  9'h010, 32'h99881234, 32'hFFFFBEEF, 1'b0, 0);
        access("ld_mix",  T_LD,   9'h010, 32'h0,        32'h1234BE55, 1'b0, 0);
        access("ldd",     T_LDD,  9'h010, 32'h0,        32'h1234BE55, 1'b0, 0);
        access("std",     T_STD,  9'h010, 32'h0,        32'h1234BE55, 1'b0, 0);
        access("swap",    T_SWAP, 9'h010, 32'hFFFFFFFF, 32'h1234BE55, 1'b0, 0);
        access("ld_unsup",T_LD,   9'h010, 32'h0,        32'h1234BE55, 1'b0, 0);
        access("hs_ldub", T_LDUB, 9'h010, 32'h0,        32'h00000012, 1'b0, 5);
        access("stw020",  T_ST,   9'h020, 32'h11223344, 32'h00000012, 1'b0, 0);

        // Reset while the store to 0x020 is waiting: no MFC, no write
        RAM_OpCode = T_ST;
        Address    = 9'h020;
        DataIn     = 32'hCAFEF00D;
        RAM_enable = 1'b1;
        @(negedge clk);
        RESET      = 1'b1;
        RAM_enable = 1'b0;
        @(negedge clk);
        RESET = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("abort_mfc", {31'd0, MFC}, 32'd0);
        end
        check("abort_dataout", DataOut, 32'd0);

        access("ld020",   T_LD,   9'h020, 32'h0,        32'h11223344, 1'b0, 0);
        access("stw022",  T_ST,   9'h022, 32'hA5A5A5A5, 32'h11223344, AE, 0);
        access("ld020b",  T_LD,   9'h020, 32'h0, AE ? 32'h11223344 : 32'hA5A5A5A5, 1'b0, 0);
        access("lduh011", T_LDUH, 9'h011, 32'h0, AE ? 32'h11223344 : 32'h00001234, AE, 0);
        access("ld013",   T_LD,   9'h013, 32'h0, AE ? 32'h11223344 : 32'h1234BE55, AE, 0);
        access("ld010",   T_LD,   9'h010, 32'h0,        32'h1234BE55, 1'b0, 0);

        repeat (3) @(negedge clk);
        check("mfc_rise_count", 32'(mfc_rises), 32'(issued));
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000 time units");
        $fatal(1);
    end

endmodule
